// File: rtl/gcd_pkg.sv
// gcd_pkg: types shared by the GCD family of blocks.
//   gcd_state_e : control state encoding (IDLE, STRIP, REDUCE, SHIFT, DONE)
package gcd_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    STRIP  = 3'd1,
    REDUCE = 3'd2,
    SHIFT  = 3'd3,
    DONE   = 3'd4
  } gcd_state_e;

endpackage

// File: rtl/gcd_stein_step.sv
// gcd_stein_step: combinational single step of the binary (Stein) GCD datapath.
// Ports:
//   state_i, a_i, b_i, k_i : current control state and working values
//   state_nxt_c            : next control state (only work states are advanced)
//   a_nxt_c, b_nxt_c       : next working operands
//   k_nxt_c                : next common power-of-two count
//   gcd_c                  : a_i << k_i, the result once a_i == b_i
module gcd_stein_step
  import gcd_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned KW    = $clog2(WIDTH)
) (
  input  gcd_state_e       state_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [KW-1:0]    k_i,
  output gcd_state_e       state_nxt_c,
  output logic [WIDTH-1:0] a_nxt_c,
  output logic [WIDTH-1:0] b_nxt_c,
  output logic [KW-1:0]    k_nxt_c,
  output logic [WIDTH-1:0] gcd_c
);

  // Restore the stripped common factor of two; fits because gcd <= min operand.
  assign gcd_c = WIDTH'(a_i << k_i);

  // Next working values for the three work states.
  always_comb begin
    state_nxt_c = state_i;
    a_nxt_c     = a_i;
    b_nxt_c     = b_i;
    k_nxt_c     = k_i;
    unique case (state_i)
      STRIP: begin
        if (!a_i[0] && !b_i[0]) begin
          a_nxt_c = a_i >> 1;
          b_nxt_c = b_i >> 1;
          k_nxt_c = k_i + KW'(1);
        end else begin
          state_nxt_c = REDUCE;
        end
      end
      REDUCE: begin
        // Both odd before subtracting, so the difference is even and the
        // shift loses nothing; subtraction only runs with minuend larger.
        if (!a_i[0]) begin
          a_nxt_c = a_i >> 1;
        end else if (!b_i[0]) begin
          b_nxt_c = b_i >> 1;
        end else if (a_i == b_i) begin
          state_nxt_c = SHIFT;
        end else if (a_i > b_i) begin
          a_nxt_c = WIDTH'(a_i - b_i) >> 1;
        end else begin
          b_nxt_c = WIDTH'(b_i - a_i) >> 1;
        end
      end
      SHIFT: begin
        state_nxt_c = DONE;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/gcd_stein.sv
// gcd_stein: binary (Stein) GCD of two WIDTH-bit unsigned operands with
// valid/ready handshakes and a per-result work-cycle count.
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   in_valid/in_ready     : operand handshake, in_a/in_b operands
//   out_valid/out_ready   : result handshake
//   out_gcd               : gcd(a, b)
//   out_zero              : at least one operand was zero
//   out_cycles            : cycles spent in STRIP+REDUCE+SHIFT
module gcd_stein
  import gcd_pkg::*;
#(
  parameter  int unsigned WIDTH = 16,
  localparam int unsigned CNT_W = $clog2(2*WIDTH+2)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_gcd,
  output logic             out_zero,
  output logic [CNT_W-1:0] out_cycles
);

  localparam int unsigned KW = $clog2(WIDTH);

  gcd_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [KW-1:0]    k_q, k_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] gcd_q, gcd_d;
  logic             zero_q, zero_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  gcd_state_e       step_state_c;
  logic [WIDTH-1:0] step_a_c;
  logic [WIDTH-1:0] step_b_c;
  logic [KW-1:0]    step_k_c;
  logic [WIDTH-1:0] step_gcd_c;

  gcd_stein_step #(
    .WIDTH (WIDTH),
    .KW    (KW)
  ) u_step (
    .state_i     (state_q),
    .a_i         (a_q),
    .b_i         (b_q),
    .k_i         (k_q),
    .state_nxt_c (step_state_c),
    .a_nxt_c     (step_a_c),
    .b_nxt_c     (step_b_c),
    .k_nxt_c     (step_k_c),
    .gcd_c       (step_gcd_c)
  );

  // Handshake control and next-state selection.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    gcd_d   = gcd_q;
    zero_d  = zero_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d   = in_a;
          b_d   = in_b;
          k_d   = '0;
          cnt_d = '0;
          // A zero operand short-circuits: gcd is the other operand.
          if (in_a == '0 || in_b == '0) begin
            state_d = DONE;
            gcd_d   = in_a | in_b;
            zero_d  = 1'b1;
          end else begin
            state_d = STRIP;
            zero_d  = 1'b0;
          end
        end
      end
      STRIP, REDUCE, SHIFT: begin
        state_d = step_state_c;
        a_d     = step_a_c;
        b_d     = step_b_c;
        k_d     = step_k_c;
        cnt_d   = cnt_q + CNT_W'(1);
        if (state_q == SHIFT) begin
          gcd_d = step_gcd_c;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Handshake flags are registered copies of the next-state decode.
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      k_q         <= '0;
      cnt_q       <= '0;
      gcd_q       <= '0;
      zero_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      k_q         <= k_d;
      cnt_q       <= cnt_d;
      gcd_q       <= gcd_d;
      zero_q      <= zero_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_gcd    = gcd_q;
  assign out_zero   = zero_q;
  assign out_cycles = cnt_q;

endmodule

// File: tb/tb_gcd_stein.sv
// tb_gcd_stein: directed and random checks of gcd_stein with a result scoreboard.
module tb_gcd_stein;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned CNT_W = $clog2(2*WIDTH+2);
  localparam int unsigned MAX_CYC = 2*WIDTH+1;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_gcd;
  logic             out_zero;
  logic [CNT_W-1:0] out_cycles;

  gcd_stein #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_gcd    (out_gcd),
    .out_zero   (out_zero),
    .out_cycles (out_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] gcd;
    logic             zero;
    int               cycles;  // -1: exact count not checked
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  function automatic int unsigned euclid(input int unsigned a, input int unsigned b);
    int unsigned x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  task automatic push_exp(input logic [WIDTH-1:0] g, input logic z, input int c);
    exp_t e;
    e.gcd    = g;
    e.zero   = z;
    e.cycles = c;
    sb.push_back(e);
  endtask

  // Present one operand pair and hold it until the accepting edge.
  task automatic accept(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int n;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
  endtask

  // Wait for a result, compare with the scoreboard, optionally stall, then release.
  task automatic collect(input string tag, input int hold);
    int   n;
    exp_t e;
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    if (sb.size() == 0) begin
      chk({tag, "_sb_nonempty"}, 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_gcd"}, 32'(out_gcd), 32'(e.gcd));
      chk({tag, "_zero"}, 32'(out_zero), 32'(e.zero));
      if (e.cycles >= 0) chk({tag, "_cycles"}, 32'(out_cycles), 32'(e.cycles));
      chk({tag, "_cycle_bound"}, 32'(out_cycles <= CNT_W'(MAX_CYC)), 32'd1);
      chk({tag, "_latency"}, 32'(n), 32'(out_cycles));
      for (int i = 0; i < hold; i++) begin
        in_valid = 1'b1;
        in_a     = WIDTH'(5);
        in_b     = WIDTH'(10);
        @(posedge clk); #1;
        chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_hold_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_hold_gcd"}, 32'(out_gcd), 32'(e.gcd));
        chk({tag, "_hold_zero"}, 32'(out_zero), 32'(e.zero));
      end
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_released"}, 32'(out_valid), 32'd0);
    chk({tag, "_ready_again"}, 32'(in_ready), 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_gcd"}, 32'(out_gcd), 32'd0);
    chk({tag, "_out_zero"}, 32'(out_zero), 32'd0);
    chk({tag, "_out_cycles"}, 32'(out_cycles), 32'd0);
  endtask

  initial begin
    logic [WIDTH-1:0] ra, rb, f;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    rst = 1'b0;
    @(posedge clk); #1;
    chk_reset_vals("post_reset");

    // Directed cases with hand-derived cycle counts.
    accept(WIDTH'(12), WIDTH'(18));  push_exp(WIDTH'(6), 1'b0, 6);      collect("g12_18", 0);
    accept(WIDTH'(48), WIDTH'(36));  push_exp(WIDTH'(12), 1'b0, 8);     collect("g48_36", 0);
    accept(WIDTH'(0), WIDTH'(7));    push_exp(WIDTH'(7), 1'b1, 0);      collect("g0_7", 0);
    accept(WIDTH'(9), WIDTH'(0));    push_exp(WIDTH'(9), 1'b1, 0);      collect("g9_0", 0);
    accept(WIDTH'(0), WIDTH'(0));    push_exp(WIDTH'(0), 1'b1, 0);      collect("g0_0", 0);
    accept(WIDTH'(65535), WIDTH'(1)); push_exp(WIDTH'(1), 1'b0, 18);    collect("g65535_1", 0);
    accept(WIDTH'(32768), WIDTH'(32768)); push_exp(WIDTH'(32768), 1'b0, 18); collect("g32768_32768", 0);
    accept(WIDTH'(7), WIDTH'(7));    push_exp(WIDTH'(7), 1'b0, 3);      collect("g7_7", 0);

    // Backpressure: result held 10 cycles while new operands are offered.
    accept(WIDTH'(12), WIDTH'(18));  push_exp(WIDTH'(6), 1'b0, 6);      collect("bp", 10);
    accept(WIDTH'(48), WIDTH'(36));  push_exp(WIDTH'(12), 1'b0, 8);     collect("after_bp", 0);

    // Random pairs against Euclid; half share a common factor.
    for (int i = 0; i < 24; i++) begin
      if (i % 2 == 0) begin
        ra = WIDTH'($urandom());
        rb = WIDTH'($urandom());
      end else begin
        f  = WIDTH'($urandom_range(1, 64));
        ra = WIDTH'(f * WIDTH'($urandom_range(1, 1000)));
        rb = WIDTH'(f * WIDTH'($urandom_range(1, 1000)));
      end
      accept(ra, rb);
      push_exp(WIDTH'(euclid(32'(ra), 32'(rb))), (ra == '0 || rb == '0), -1);
      collect($sformatf("rand%0d", i), 0);
    end

    // Reset in the middle of REDUCE discards the operation.
    accept(WIDTH'(65535), WIDTH'(1));
    repeat (4) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    chk_reset_vals("mid_rst");
    @(posedge clk); #1;
    chk_reset_vals("mid_rst_hold");
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("mid_rst_no_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_idle", 32'(in_ready), 32'd1);
    accept(WIDTH'(12), WIDTH'(18));  push_exp(WIDTH'(6), 1'b0, 6);      collect("after_rst", 0);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
